// File: rtl/vrf_group_writeback.sv
// vrf_group_writeback
//   Writes the result of a grouped (LMUL>1) vector operation back to the VRF.
//   Accepts one VLEN-bit result beat per register of the destination group and
//   issues a registered VRF write for each, masking bytes past vl so that tail
//   elements are left undisturbed.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start               begin a group writeback (sampled only in IDLE)
//   lmul_encoded_id     000=1 001=2 010=4 011=8, others reserved
//   sew_encoded_id      000=8 001=16 010=32 011=64, others reserved
//   AVL                 application vector length in elements
//   wa_base             first register of the destination group
//   res_valid/res_ready result beat handshake, res_data = beat
//   busy                high outside IDLE
//   wa/wd/wen/wbe       VRF write port (registered, one cycle after handshake)
//   done/err            one-cycle completion pulse, err = configuration rejected
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; config is validated and latched on start
// WRITE | accepting beats, one per group register
// FIN   | done pulse (err reflects rejected config), then back to IDLE
module vrf_group_writeback #(
  parameter int VLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      lmul_encoded_id,
  input  logic [2:0]      sew_encoded_id,
  input  logic [7:0]      AVL,
  input  logic [4:0]      wa_base,
  input  logic            res_valid,
  input  logic [VLEN-1:0] res_data,
  output logic            res_ready,
  output logic            busy,
  output logic [4:0]      wa,
  output logic [VLEN-1:0] wd,
  output logic            wen,
  output logic [VLEN/8-1:0] wbe,
  output logic            done,
  output logic            err
);

  localparam int BEAT_BYTES = VLEN / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2:0] beat;
  logic [3:0] lmul_r;
  logic [4:0] base_r;
  logic [6:0] vlbytes_r;
  logic       err_r;

  // Configuration decode, evaluated against the raw inputs during IDLE.
  logic [3:0] lmul_val;
  logic [2:0] vlmax_sh;
  logic [6:0] vlmax;
  logic [6:0] vl;
  logic [6:0] vlbytes;
  logic       cfg_err;

  assign lmul_val = 4'd1 << lmul_encoded_id[1:0];

  // VLMAX = LMUL*VLEN/SEW = 2^(3 + lmul_log - sew_log) for VLEN=64, SEW=8<<sew_log.
  assign vlmax_sh = 3'd3 + {1'b0, lmul_encoded_id[1:0]} - {1'b0, sew_encoded_id[1:0]};
  assign vlmax    = 7'd1 << vlmax_sh;
  assign vl       = ({1'b0, AVL} < {2'b0, vlmax}) ? AVL[6:0] : vlmax;
  // vl*SEW/8 never exceeds LMUL*8 = 64, so 7 bits cannot overflow.
  assign vlbytes  = vl << sew_encoded_id[1:0];

  assign cfg_err = lmul_encoded_id[2]
                 | sew_encoded_id[2]
                 | ((wa_base[3:0] & (lmul_val - 4'd1)) != 4'd0)
                 | (({2'b0, wa_base} + {3'b0, lmul_val}) > 7'(NREG));

  logic                  hs;
  logic                  last_beat;
  logic [BEAT_BYTES-1:0] wbe_next;

  assign hs        = (state == WRITE) && res_valid;
  assign last_beat = ({1'b0, beat} == (lmul_r - 4'd1));

  always_comb begin
    wbe_next = '0;
    for (int b = 0; b < BEAT_BYTES; b++) begin
      wbe_next[b] = (({1'b0, beat, 3'b000} + 7'(b)) < vlbytes_r);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = cfg_err ? FIN : WRITE;
      WRITE:   if (hs && last_beat) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign res_ready = (state == WRITE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign err       = (state == FIN) && err_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat      <= '0;
      lmul_r    <= '0;
      base_r    <= '0;
      vlbytes_r <= '0;
      err_r     <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        beat      <= '0;
        lmul_r    <= lmul_val;
        base_r    <= wa_base;
        vlbytes_r <= vlbytes;
        err_r     <= cfg_err;
      end
    end else if (hs) begin
      beat <= beat + 3'd1;
    end
  end

  // Write port: a beat past vl is still consumed and its address/data/mask
  // registered, but wen stays low so the register is not disturbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wa  <= '0;
      wd  <= '0;
      wbe <= '0;
      wen <= 1'b0;
    end else begin
      wen <= hs && (wbe_next != '0);
      if (hs) begin
        wa  <= base_r + {2'b0, beat};
        wd  <= res_data;
        wbe <= wbe_next;
      end
    end
  end

endmodule

// File: doc/vrf_group_writeback.md
Name: vrf_group_writeback

Overview:
- Writes back the result of a grouped (LMUL>1) vector operation to the vector register file.
- Takes one 64-bit ALU result beat per register of the destination group over a valid/ready handshake.
- For each beat, drives wa/wd/wen into the VRF write port, plus per-byte enables that leave tail elements past vl undisturbed.
- Sits between the grouped ALU output and the VRF write port. It is the write-side counterpart of the register-group read sequencing.

Parameters:
- VLEN, 64, bits per vector register (beat width).
- NREG, 32, number of architectural vector registers.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a group writeback; sampled only in IDLE
- lmul_encoded_id  in  3  000=1, 001=2, 010=4, 011=8; others reserved
- sew_encoded_id  in  3  000=8, 001=16, 010=32, 011=64 bits; others reserved
- AVL  in  8  application vector length, in elements
- wa_base  in  5  first register of the destination group
- res_valid  in  1  result beat valid
- res_data  in  64  result beat; byte 0 = bits [7:0] = lowest element
- res_ready  out  1  beat accepted when res_valid & res_ready
- busy  out  1  high in any state other than IDLE
- wa  out  5  VRF write address
- wd  out  64  VRF write data
- wen  out  1  VRF write enable
- wbe  out  8  VRF byte enables, valid with wen
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; 1 = configuration rejected

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, beat counter=0. All outputs are 0: res_ready, busy, wa, wd, wen, wbe, done, err.
- Reset mid-operation: abort immediately with no done pulse. Writes already issued are not rolled back.
- States: IDLE, WRITE, FIN.
- IDLE:
  - res_ready=0.
  - On start: latch all config inputs.
  - Error if any of: lmul reserved; sew reserved; wa_base not a multiple of LMUL; wa_base+LMUL > NREG.
  - On error: go to FIN with err latched 1; no beats are accepted and no writes are issued.
  - Otherwise: go to WRITE with beat=0.
- Length computation, done at start:
  - VLMAX = LMUL*VLEN/SEW.
  - vl = min(AVL, VLMAX).
  - vlbytes = vl*SEW/8, range 0..64, held in 7 bits.
- WRITE:
  - res_ready=1.
  - On a handshake at beat k, in the next cycle (registered, 1-cycle latency):
    - wa = wa_base+k
    - wd = res_data
    - wbe[b] = ((8k+b) < vlbytes)
    - wen = 1 only if wbe != 0
  - A beat whose wbe is all zero is consumed, but wen stays 0 for it.
  - Without a handshake, wen=0 next cycle, and wa/wd/wbe hold their previous values.
  - k increments per handshake. The handshake at k=LMUL-1 moves the FSM to FIN, and res_ready drops in the same transition, so exactly LMUL beats are accepted.
- FIN:
  - done=1 and err=latched flag, for exactly 1 cycle; then back to IDLE.
  - The last write (wen) and done are asserted in the same cycle.
- Edge cases:
  - start while busy is ignored.
  - AVL=0 gives vl=0: all LMUL beats are consumed, no wen, done with err=0.
  - AVL > VLMAX clamps to VLMAX.
  - Address wrap past register 31 cannot occur, because it is rejected by the error check.

Test Plan:
- LMUL=4 (010), SEW=8 (000), AVL=16, wa_base=8, 4 back-to-back beats -> wen on wa=8 and wa=9 with wbe=FF; beats 3–4 consumed with wen=0; done=1, err=0 in the cycle of the 4th beat's output.
- LMUL=2 (001), SEW=32 (010), AVL=3, wa_base=10, beats 0x..AA, 0x..BB -> wa=10 wbe=FF; wa=11 wbe=0F; wd equals beat data.
- LMUL=1, SEW=8, AVL=200, wa_base=0 -> vl clamps to 8; single write wa=0, wbe=FF; done.
- LMUL=4, wa_base=6 (misaligned); also lmul=100 (reserved) -> done=1, err=1 one cycle after start; res_ready never asserted; wen never asserted.
- LMUL=2, SEW=8, AVL=16, res_valid deasserted for 3 cycles between beats -> no wen during the gap; second write goes to wa_base+1 once valid returns; done follows.
- Drive rst low after the first beat of an LMUL=8 op -> all outputs 0 at once, busy=0, no done. A new start after reset release completes normally.
